// File: rtl/fact_result_reader_if.sv
// Result-path bus for fact_result_reader: core write handshake plus CPU read port.
// The master side is the core and CPU; the slave side is the reader block.
interface fact_result_reader_if #(
    parameter int w = 32
);
    logic         Res_Valid;
    logic [w-1:0] Res_Data;
    logic         Res_Err;
    logic         Res_Ready;
    logic         Rd_En;
    logic [1:0]   Rd_Addr;
    logic [w-1:0] Rd_Data;
    logic         Rd_Valid;

    modport master (
        output Res_Valid, Res_Data, Res_Err, Rd_En, Rd_Addr,
        input  Res_Ready, Rd_Data, Rd_Valid
    );

    modport slave (
        input  Res_Valid, Res_Data, Res_Err, Rd_En, Rd_Addr,
        output Res_Ready, Rd_Data, Rd_Valid
    );
endinterface

// File: rtl/fact_result_reader.sv
// Result FIFO between the factorial core and the CPU read mux, 1-cycle registered reads.
// Optional FACT_RD_IRQ_EN adds a registered Irq pulse when the FIFO leaves empty.
module fact_result_reader #(
    parameter int w     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    fact_result_reader_if.slave   bus
`ifdef FACT_RD_IRQ_EN
    ,
    output logic                  Irq
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [w:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          underflow_r;
    logic          underflow_nxt_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          rd_pop_s;
    logic          pop_s;
    logic          pop_empty_s;
    logic          status_rd_s;
    logic [w:0]    head_s;
    logic [w-1:0]  rd_data_r;
    logic [w-1:0]  rd_data_nxt_s;
    rd_state_e     state_r;
    rd_state_e     state_nxt_s;
    logic          rd_valid_s;

    // Status word; head err is masked when empty because the head slot is stale.
    function automatic logic [w-1:0] build_status(
        input logic [AW:0] cnt,
        input logic        not_empty,
        input logic        is_full,
        input logic        head_err,
        input logic        uflow
    );
        logic [w-1:0] s;
        s = {w{1'b0}};
        s[0] = not_empty;
        s[1] = is_full;
        s[2] = head_err & not_empty;
        s[3] = uflow;
        s[4 +: AW+1] = cnt;
        return s;
    endfunction

    assign empty_s     = (count_r == {(AW+1){1'b0}});
    assign full_s      = (count_r == FULL_CNT);
    assign head_s      = mem_r[rptr_r];
    assign push_s      = bus.Res_Valid & ~full_s;
    assign rd_pop_s    = bus.Rd_En & (bus.Rd_Addr == 2'b01);
    assign pop_s       = rd_pop_s & ~empty_s;
    assign pop_empty_s = rd_pop_s & empty_s;
    assign status_rd_s = bus.Rd_En & (bus.Rd_Addr == 2'b00);
    assign bus.Res_Ready = ~full_s;

    // Next occupancy and sticky underflow; a status read clears underflow after returning it.
    always_comb begin
        count_nxt_s     = count_r;
        underflow_nxt_s = underflow_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + (AW+1)'(1'b1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - (AW+1)'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
        if (pop_empty_s) begin
            underflow_nxt_s = 1'b1;
        end else if (status_rd_s) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
    end

    // Entry storage; contents need no reset since pointers define validity.
    always_ff @(posedge Clk) begin
        if (push_s && !Rst) begin
            mem_r[wptr_r] <= {bus.Res_Err, bus.Res_Data};
        end
    end

    // Pointers, occupancy and underflow flag.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_r      <= {AW{1'b0}};
            rptr_r      <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            underflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1'b1);
            end
            count_r     <= count_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Read data selection; holds the last response when no read is issued.
    always_comb begin
        rd_data_nxt_s = rd_data_r;
        if (bus.Rd_En) begin
            case (bus.Rd_Addr)
                2'b00:   rd_data_nxt_s = build_status(count_r, ~empty_s, full_s,
                                                      head_s[w], underflow_r);
                2'b01:   rd_data_nxt_s = empty_s ? {w{1'b0}} : head_s[w-1:0];
                2'b10:   rd_data_nxt_s = empty_s ? {w{1'b0}} : head_s[w-1:0];
                2'b11:   rd_data_nxt_s = {{(w-AW-1){1'b0}}, count_r};
                default: rd_data_nxt_s = {w{1'b0}};
            endcase
        end else begin
            rd_data_nxt_s = rd_data_r;
        end
    end

    // Read data register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_data_r <= {w{1'b0}};
        end else begin
            rd_data_r <= rd_data_nxt_s;
        end
    end

    // Response FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Response FSM next state; a new strobe in RESP keeps it there for back-to-back reads.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = bus.Rd_En ? RESP : IDLE;
            RESP:    state_nxt_s = bus.Rd_En ? RESP : IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Response FSM outputs.
    always_comb begin
        rd_valid_s = 1'b0;
        case (state_r)
            IDLE:    rd_valid_s = 1'b0;
            RESP:    rd_valid_s = 1'b1;
            default: rd_valid_s = 1'b0;
        endcase
    end

    assign bus.Rd_Data  = rd_data_r;
    assign bus.Rd_Valid = rd_valid_s;

`ifdef FACT_RD_IRQ_EN
    logic irq_r;

    // Pulse on the cycle the stored count first becomes nonzero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (count_r == {(AW+1){1'b0}}) && (count_nxt_s != {(AW+1){1'b0}});
        end
    end

    assign Irq = irq_r;
`endif

endmodule
